csr_apb_ctrl: RTL and testbench

APB slave controller that sequences the CSR block: it runs the APB setup/access handshake, drives the 3-bit CSR address decoder (`o_dec_addr`/`o_dec_en`), and owns eight 8-bit CSRs. CSR 7 is a read-only status register sourced from `i_status`. The block sits between the APB bus and the decoder/register datapath, and handles wait-state insertion and slave-error signalling.

---
 rtl/csr_apb_pkg.sv | 14 +
 rtl/csr_apb_fsm.sv | 69 ++++++
 rtl/csr_apb_ctrl.sv | 96 +++++++++
 tb/tb_csr_apb_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/csr_apb_pkg.sv
// Shared types and constants for the APB CSR controller (csr_apb_fsm, csr_apb_ctrl).
package csr_apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACCESS = 2'b10
  } state_t;

  localparam int unsigned CSR_NUM    = 8;
  localparam int unsigned CSR_W      = 8;
  localparam int unsigned STATUS_IDX = 7;

endpackage

// File: rtl/csr_apb_fsm.sv
// APB handshake sequencer: state, optional wait counter (CSR_WAIT_EN), ready/error and strobes.
// Without CSR_WAIT_EN the transfer is zero-wait and WAIT_CYCLES has no effect.
module csr_apb_fsm
  import csr_apb_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic psel,
  input  logic penable,
  input  logic err,
  output logic pready,
  output logic pslverr,
  output logic in_setup,
  output logic complete
);

  state_t state_q, state_d;
  logic   ready;

  if (WAIT_CYCLES > 15) begin : g_wait_range
    $error("csr_apb_fsm: WAIT_CYCLES must be in 0..15");
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

`ifdef CSR_WAIT_EN
  logic [3:0] wait_cnt_q;
  logic       abort;

  // psel dropped while still waiting: leave without completing
  assign abort = (state_q == ACCESS) && !ready && !psel;
  assign ready = (state_q == ACCESS) && (wait_cnt_q == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                         wait_cnt_q <= '0;
    else if (state_q == SETUP)                       wait_cnt_q <= 4'(WAIT_CYCLES);
    else if (abort)                                  wait_cnt_q <= '0;
    else if (state_q == ACCESS && wait_cnt_q != '0)  wait_cnt_q <= wait_cnt_q - 4'd1;
  end
`else
  assign ready = (state_q == ACCESS);
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (psel && !penable) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS: begin
        if (ready)      state_d = (psel && !penable) ? SETUP : IDLE;
        else if (!psel) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pready   = ready;
    pslverr  = ready && err;
    in_setup = (state_q == SETUP);
    complete = ready;
  end

endmodule

// File: rtl/csr_apb_ctrl.sv
// APB slave owning eight 8-bit CSRs (CSR 7 = live i_status, read-only) and driving the
// 3-bit CSR decoder. Wait-state insertion is enabled by defining CSR_WAIT_EN.
module csr_apb_ctrl
  import csr_apb_pkg::*;
#(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_psel,
  input  logic                       i_penable,
  input  logic                       i_pwrite,
  input  logic [ADDR_W-1:0]          i_paddr,
  input  logic [CSR_W-1:0]           i_pwdata,
  input  logic [CSR_W-1:0]           i_status,
  output logic [CSR_W-1:0]           o_prdata,
  output logic                       o_pready,
  output logic                       o_pslverr,
  output logic [2:0]                 o_dec_addr,
  output logic                       o_dec_en,
  output logic [CSR_NUM*CSR_W-1:0]   o_csr
);

  logic [CSR_W-1:0] csr_q [STATUS_IDX];
  logic [2:0]       dec_addr_q;
  logic             wr_q;
  logic             err_q;
  logic [CSR_W-1:0] prdata_q;

  logic [2:0]       idx;
  logic             req_err;
  logic [CSR_W-1:0] rd_val;
  logic             in_setup;
  logic             complete;

  csr_apb_fsm #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_fsm (
    .clk      (i_clk),
    .rst      (i_rst),
    .psel     (i_psel),
    .penable  (i_penable),
    .err      (err_q),
    .pready   (o_pready),
    .pslverr  (o_pslverr),
    .in_setup (in_setup),
    .complete (complete)
  );

  always_comb begin
    idx     = i_paddr[2:0];
    req_err = ((i_paddr >> 3) != '0) || (i_pwrite && (idx == 3'(STATUS_IDX)));
    rd_val  = i_status;
    for (int unsigned i = 0; i < STATUS_IDX; i++) begin
      if (idx == 3'(i)) rd_val = csr_q[i];
    end
  end

  // Address, direction, error and read data are frozen at the end of SETUP
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      dec_addr_q <= '0;
      wr_q       <= 1'b0;
      err_q      <= 1'b0;
      prdata_q   <= '0;
    end else if (in_setup) begin
      dec_addr_q <= idx;
      wr_q       <= i_pwrite;
      err_q      <= req_err;
      prdata_q   <= req_err ? '0 : rd_val;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < STATUS_IDX; i++) csr_q[i] <= '0;
    end else if (complete && wr_q && !err_q) begin
      for (int unsigned i = 0; i < STATUS_IDX; i++) begin
        if (dec_addr_q == 3'(i)) csr_q[i] <= i_pwdata;
      end
    end
  end

  always_comb begin
    o_prdata   = prdata_q;
    o_dec_addr = dec_addr_q;
    o_dec_en   = complete && wr_q && !err_q;
    o_csr      = '0;
    for (int unsigned i = 0; i < STATUS_IDX; i++) begin
      o_csr[i*CSR_W +: CSR_W] = csr_q[i];
    end
    o_csr[STATUS_IDX*CSR_W +: CSR_W] = i_status;
  end

endmodule

// File: tb/tb_csr_apb_ctrl.sv
// Self-checking bench for csr_apb_ctrl: directed APB scenarios plus randomized transfers
// checked against a register-array reference model.
module tb_csr_apb_ctrl;

`ifdef CSR_WAIT_EN
  localparam int unsigned EXP_WAIT = 3;
`else
  localparam int unsigned EXP_WAIT = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        psel, penable, pwrite;
  logic [7:0]  paddr, pwdata, status;
  logic [7:0]  prdata;
  logic        pready, pslverr, dec_en;
  logic [2:0]  dec_addr;
  logic [63:0] csr;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned dec_en_pulses = 0;
  logic [7:0]  model [8];

  csr_apb_ctrl #(
    .ADDR_W(8),
    .WAIT_CYCLES(3)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_psel     (psel),
    .i_penable  (penable),
    .i_pwrite   (pwrite),
    .i_paddr    (paddr),
    .i_pwdata   (pwdata),
    .i_status   (status),
    .o_prdata   (prdata),
    .o_pready   (pready),
    .o_pslverr  (pslverr),
    .o_dec_addr (dec_addr),
    .o_dec_en   (dec_en),
    .o_csr      (csr)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (dec_en === 1'b1) dec_en_pulses++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] model_csr();
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < 7; i++) v[i*8 +: 8] = model[i];
    v[63:56] = status;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // from_setup: previous transfer chained, DUT already in SETUP. chain: request back-to-back.
  task automatic xfer(input bit wr, input logic [7:0] addr, input logic [7:0] data,
                      input bit from_setup, input bit chain);
    bit          exp_err, done;
    logic [7:0]  exp_rd;
    int unsigned acc, pulses0;
    exp_err = (addr > 8'd7) || (wr && addr == 8'd7);
    exp_rd  = exp_err ? 8'h00 : (addr == 8'd7 ? status : model[addr[2:0]]);
    pulses0 = dec_en_pulses;
    pwrite = wr; paddr = addr; pwdata = data;
    if (!from_setup) begin
      psel = 1'b1; penable = 1'b0;
      tick();
    end
    penable = 1'b1;
    tick();
    acc = 1; done = 1'b0;
    while (!done && acc <= 20) begin
      if (pready === 1'b1) done = 1'b1;
      else begin tick(); acc++; end
    end
    check("pready_seen", 64'(done), 64'd1);
    check("access_cycles", 64'(acc), 64'(EXP_WAIT + 1));
    check("pslverr", 64'(pslverr), 64'(exp_err));
    check("dec_addr", 64'(dec_addr), 64'(addr[2:0]));
    check("prdata", 64'(prdata), 64'(exp_rd));
    if (chain) penable = 1'b0;
    tick();
    if (!chain) begin psel = 1'b0; penable = 1'b0; end
    if (wr && !exp_err) model[addr[2:0]] = data;
    check("dec_en_pulses", 64'(dec_en_pulses - pulses0), 64'(wr && !exp_err));
    check("csr", csr, model_csr());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          chained, wr, ch;
    logic [7:0]  a, d;
    int unsigned pulses0;
    logic [63:0] csr_before;

    rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; status = 8'h3C;
    for (int i = 0; i < 8; i++) model[i] = 8'h00;
    tick(); tick();
    rst = 1'b0;
    tick();

    check("rst_prdata", 64'(prdata), 64'h0);
    check("rst_pready", 64'(pready), 64'h0);
    check("rst_pslverr", 64'(pslverr), 64'h0);
    check("rst_dec_addr", 64'(dec_addr), 64'h0);
    check("rst_dec_en", 64'(dec_en), 64'h0);
    check("rst_csr", csr, model_csr());

    xfer(1'b1, 8'd3, 8'hA5, 1'b0, 1'b0);
    xfer(1'b0, 8'd3, 8'h00, 1'b0, 1'b0);
    check("csr3_byte", 64'(csr[31:24]), 64'hA5);

    status = 8'h96;
    xfer(1'b1, 8'd7, 8'hFF, 1'b0, 1'b0);
    xfer(1'b0, 8'h08, 8'h00, 1'b0, 1'b0);
    xfer(1'b0, 8'd7, 8'h00, 1'b0, 1'b0);

    pulses0 = dec_en_pulses;
    xfer(1'b1, 8'd1, 8'h11, 1'b0, 1'b1);
    xfer(1'b1, 8'd2, 8'h22, 1'b1, 1'b0);
    check("b2b_pulses", 64'(dec_en_pulses - pulses0), 64'd2);
    check("b2b_bytes", 64'(csr[23:8]), 64'h2211);

`ifdef CSR_WAIT_EN
    pulses0 = dec_en_pulses;
    csr_before = csr;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'd5; pwdata = 8'hC3;
    tick();
    penable = 1'b1;
    tick();
    check("abort_pready_acc1", 64'(pready), 64'h0);
    tick();
    check("abort_pready_acc2", 64'(pready), 64'h0);
    psel = 1'b0; penable = 1'b0;
    tick();
    check("abort_pready_idle", 64'(pready), 64'h0);
    check("abort_pslverr", 64'(pslverr), 64'h0);
    check("abort_csr", csr, csr_before);
    check("abort_pulses", 64'(dec_en_pulses - pulses0), 64'd0);
    xfer(1'b0, 8'd5, 8'h00, 1'b0, 1'b0);
`endif

    pulses0 = dec_en_pulses;
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 8'd0; pwdata = 8'hEE;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idle_penable_pready", 64'(pready), 64'h0);
    end
    psel = 1'b0; penable = 1'b0;
    tick();
    check("idle_penable_pulses", 64'(dec_en_pulses - pulses0), 64'd0);
    check("idle_penable_csr", csr, model_csr());

    xfer(1'b1, 8'd4, 8'h33, 1'b0, 1'b0);
    pulses0 = dec_en_pulses;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'd4; pwdata = 8'h5A;
    tick();
    penable = 1'b1;
    tick();
    #2 rst = 1'b1;
    #1;
    check("mid_rst_prdata", 64'(prdata), 64'h0);
    check("mid_rst_pready", 64'(pready), 64'h0);
    check("mid_rst_pslverr", 64'(pslverr), 64'h0);
    check("mid_rst_dec_addr", 64'(dec_addr), 64'h0);
    check("mid_rst_dec_en", 64'(dec_en), 64'h0);
    psel = 1'b0; penable = 1'b0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) model[i] = 8'h00;
    tick();
    check("mid_rst_csr", csr, model_csr());
    check("mid_rst_pulses", 64'(dec_en_pulses - pulses0), 64'd0);
    xfer(1'b1, 8'd4, 8'h5A, 1'b0, 1'b0);
    xfer(1'b0, 8'd4, 8'h00, 1'b0, 1'b0);

    chained = 1'b0;
    for (int n = 0; n < 48; n++) begin
      wr = 1'($urandom_range(0, 1));
      a  = 8'($urandom_range(0, 11));
      d  = 8'($urandom);
      ch = ($urandom_range(0, 3) == 0) && (n < 47);
      if (!chained) status = 8'($urandom);
      xfer(wr, a, d, chained, ch);
      chained = ch;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
